// File: rtl/seg7_scan_driver_if.sv
// Bundle between the digit generator and the seven-segment scan driver.
// The digit generator side is the master; the scan driver is the slave.
// Optional macro SEG7_DIM_EN adds the two-bit brightness code.
interface seg7_scan_driver_if;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] C;
    logic [3:0] D;
    logic [3:0] blank;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_start;
`ifdef SEG7_DIM_EN
    logic [1:0] bright;

    modport master (output A, B, C, D, blank, bright,
                    input  seg, dp, an, frame_start);
    modport slave  (input  A, B, C, D, blank, bright,
                    output seg, dp, an, frame_start);
`else
    modport master (output A, B, C, D, blank,
                    input  seg, dp, an, frame_start);
    modport slave  (input  A, B, C, D, blank,
                    output seg, dp, an, frame_start);
`endif
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Digit codes and blank mask are captured once per frame into shadow
// registers so a scan frame never mixes old and new data. Each digit slot
// lasts REFRESH_DIV cycles and begins with GUARD dark cycles to stop ghosting.
// Optional macro SEG7_DIM_EN: shortens the lit part of each slot according
// to a brightness code captured with the frame.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD       = 16
) (
    input  logic              clk,
    input  logic              reset,
    seg7_scan_driver_if.slave bus
);
    localparam int unsigned   CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [31:0]   GUARD_W  = 32'(GUARD);
    localparam logic [31:0]   DIV_W    = 32'(REFRESH_DIV);

    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [1:0]        idx_reg, idx_next;
    logic              tick;
    logic              load;
    // Shadow codes indexed by slot: [0]=D ... [3]=A, matching the anode bit.
    logic [3:0][3:0]   shadow_code_reg, shadow_code_next;
    logic [3:0]        shadow_blank_reg, shadow_blank_next;
    logic              frame_start_reg;
    logic [3:0]        an_reg, an_next;
    logic [6:0]        seg_reg, seg_next;
    logic [3:0]        sel_code;
    logic              sel_blank;
    logic [31:0]       on_limit;
    logic              lit;
`ifdef SEG7_DIM_EN
    logic [1:0]        bright_reg, bright_next;
`endif

    // Active-low {g,f,e,d,c,b,a} pattern for a hex digit.
    function automatic logic [6:0] hex_decode(input logic [3:0] code);
        logic [6:0] pattern;
        case (code)
            4'h0: pattern = 7'h40;
            4'h1: pattern = 7'h79;
            4'h2: pattern = 7'h24;
            4'h3: pattern = 7'h30;
            4'h4: pattern = 7'h19;
            4'h5: pattern = 7'h12;
            4'h6: pattern = 7'h02;
            4'h7: pattern = 7'h78;
            4'h8: pattern = 7'h00;
            4'h9: pattern = 7'h10;
            4'hA: pattern = 7'h08;
            4'hB: pattern = 7'h03;
            4'hC: pattern = 7'h46;
            4'hD: pattern = 7'h21;
            4'hE: pattern = 7'h06;
            default: pattern = 7'h0E;
        endcase
        return pattern;
    endfunction

    // Prescaler and slot index; a frame load happens as slot 3 wraps to slot 0.
    always_comb begin
        tick     = (cnt_reg == CNT_LAST);
        load     = tick && (idx_reg == 2'd3);
        cnt_next = tick ? '0 : cnt_reg + CW'(1);
        idx_next = tick ? idx_reg + 2'd1 : idx_reg;
    end

    // Shadow capture: inputs are only looked at on the load edge.
    always_comb begin
        shadow_code_next  = shadow_code_reg;
        shadow_blank_next = shadow_blank_reg;
`ifdef SEG7_DIM_EN
        bright_next       = bright_reg;
`endif
        if (load) begin
            shadow_code_next[0] = bus.D;
            shadow_code_next[1] = bus.C;
            shadow_code_next[2] = bus.B;
            shadow_code_next[3] = bus.A;
            shadow_blank_next   = bus.blank;
`ifdef SEG7_DIM_EN
            bright_next         = bus.bright;
`endif
        end
    end

    // Digit selection and lit window, computed from next-state so the
    // registered outputs line up with the slot they belong to.
    always_comb begin
        sel_code  = shadow_code_next[idx_next];
        sel_blank = shadow_blank_next[idx_next];
`ifdef SEG7_DIM_EN
        on_limit  = GUARD_W + ((DIV_W - GUARD_W) * (32'(bright_next) + 32'd1)) / 32'd4;
`else
        on_limit  = DIV_W;
`endif
        lit       = !sel_blank && (32'(cnt_next) >= GUARD_W) && (32'(cnt_next) < on_limit);
        seg_next  = sel_blank ? 7'h7F : hex_decode(sel_code);
    end

    // One anode per slot; only the slot's own anode can ever go low.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_anode
            assign an_next[gi] = !(lit && (idx_next == 2'(gi)));
        end
    endgenerate

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg          <= '0;
            idx_reg          <= 2'd0;
            shadow_code_reg  <= '0;
            shadow_blank_reg <= 4'b1111;
            frame_start_reg  <= 1'b0;
            an_reg           <= 4'b1111;
            seg_reg          <= 7'h7F;
`ifdef SEG7_DIM_EN
            bright_reg       <= 2'd3;
`endif
        end else begin
            cnt_reg          <= cnt_next;
            idx_reg          <= idx_next;
            shadow_code_reg  <= shadow_code_next;
            shadow_blank_reg <= shadow_blank_next;
            frame_start_reg  <= load;
            an_reg           <= an_next;
            seg_reg          <= seg_next;
`ifdef SEG7_DIM_EN
            bright_reg       <= bright_next;
`endif
        end
    end

    assign bus.seg         = seg_reg;
    assign bus.an          = an_reg;
    assign bus.dp          = 1'b1;
    assign bus.frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (REFRESH_DIV=8, GUARD=2).
// Compile with +define+SEG7_DIM_EN to also exercise the brightness control.
module tb_seg7_scan_driver;
    localparam int RD    = 8;
    localparam int GD    = 2;
    localparam int FRAME = 4 * RD;
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic clk = 1'b0;
    logic reset = 1'b0;
    seg7_scan_driver_if bus();

    seg7_scan_driver #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: k = posedges since the counters were last in reset state.
    int         k = 0;
    bit         m_in_reset = 1'b1;
    logic [3:0] m_code [4];
    logic [3:0] m_blank = 4'hF;
    int         m_bright = 3;

    typedef struct packed {
        logic [3:0]      a, b, c, d, blank;
        logic [3:0][3:0] exp_an;
        logic [3:0][6:0] exp_seg;
    } vec_t;
    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h (k=%0d)", name, actual, expected, k);
        end
    endtask

    task automatic compare_outputs();
        int cnt, idx, lim;
        bit lit;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic e_fs;
        if (m_in_reset) begin
            e_an = 4'hF; e_seg = 7'h7F; e_fs = 1'b0;
        end else begin
            cnt = k % RD;
            idx = (k / RD) % 4;
            lim = RD;
`ifdef SEG7_DIM_EN
            lim = GD + ((RD - GD) * (m_bright + 1)) / 4;
`endif
            lit   = !m_blank[idx] && (cnt >= GD) && (cnt < lim);
            e_an  = lit ? ~(4'b0001 << idx) : 4'hF;
            e_seg = m_blank[idx] ? 7'h7F : HEX[m_code[idx]];
            e_fs  = (k > 0) && (k % FRAME == 0);
        end
        check("an", 32'(bus.an), 32'(e_an));
        check("seg", 32'(bus.seg), 32'(e_seg));
        check("dp", 32'(bus.dp), 32'd1);
        check("frame_start", 32'(bus.frame_start), 32'(e_fs));
        check("an_at_most_one_low", 32'($countones(~bus.an) <= 1), 32'd1);
    endtask

    // One clock: note what the DUT sees at the edge, advance model, compare.
    task automatic step();
        logic rst_edge;
        logic [3:0] a, b, c, d, bl;
        int br;
        rst_edge = reset;
        a = bus.A; b = bus.B; c = bus.C; d = bus.D; bl = bus.blank;
        br = 3;
`ifdef SEG7_DIM_EN
        br = int'(bus.bright);
`endif
        @(posedge clk);
        #1;
        if (!rst_edge) begin
            k = 0; m_in_reset = 1'b1; m_blank = 4'hF; m_bright = 3;
            for (int i = 0; i < 4; i++) m_code[i] = 4'h0;
        end else begin
            k++;
            m_in_reset = 1'b0;
            if (k % FRAME == 0) begin
                m_code[0] = d; m_code[1] = c; m_code[2] = b; m_code[3] = a;
                m_blank = bl; m_bright = br;
            end
        end
        compare_outputs();
    endtask

    task automatic run_to(input int phase);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((k % FRAME) != phase && n < 2 * FRAME);
        check("run_to_bound", 32'(k % FRAME), 32'(phase));
    endtask

    task automatic set_inputs(input logic [3:0] a, b, c, d, bl);
        bus.A = a; bus.B = b; bus.C = c; bus.D = d; bus.blank = bl;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_code[i] = 4'h0;
        vecs[0].a = 4'h0; vecs[0].b = 4'hA; vecs[0].c = 4'h4; vecs[0].d = 4'hC; vecs[0].blank = 4'b1000;
        vecs[0].exp_an  = {4'b1111, 4'b1011, 4'b1101, 4'b1110};
        vecs[0].exp_seg = {7'h7F, 7'h08, 7'h19, 7'h46};
        vecs[1].a = 4'h8; vecs[1].b = 4'hB; vecs[1].c = 4'hE; vecs[1].d = 4'h1; vecs[1].blank = 4'b0000;
        vecs[1].exp_an  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
        vecs[1].exp_seg = {7'h00, 7'h03, 7'h06, 7'h79};
        vecs[2].a = 4'hF; vecs[2].b = 4'h9; vecs[2].c = 4'h2; vecs[2].d = 4'h7; vecs[2].blank = 4'b0101;
        vecs[2].exp_an  = {4'b0111, 4'b1111, 4'b1101, 4'b1111};
        vecs[2].exp_seg = {7'h0E, 7'h7F, 7'h24, 7'h7F};
        vecs[3].a = 4'h3; vecs[3].b = 4'h5; vecs[3].c = 4'h6; vecs[3].d = 4'hD; vecs[3].blank = 4'b0000;
        vecs[3].exp_an  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
        vecs[3].exp_seg = {7'h30, 7'h12, 7'h02, 7'h21};

        set_inputs(4'h1, 4'h2, 4'h3, 4'h4, 4'b0000);
`ifdef SEG7_DIM_EN
        bus.bright = 2'd3;
`endif

        // Reset held for three cycles.
        reset = 1'b0;
        repeat (3) step();
        check("reset_an", 32'(bus.an), 32'hF);
        check("reset_seg", 32'(bus.seg), 32'h7F);
        $display("reset: an=%b seg=%h dp=%b frame_start=%b", bus.an, bus.seg, bus.dp, bus.frame_start);

        // Release: dark until the first frame_start at cycle 32.
        reset = 1'b1;
        run_to(FRAME - 1);
        check("no_early_frame_start", 32'(bus.frame_start), 32'd0);
        step();
        check("first_frame_start", 32'(bus.frame_start), 32'd1);
        $display("first frame_start at cycle %0d", k);

        // Table vectors: load each one, then sample every slot at cnt=5.
        for (int v = 0; v < 4; v++) begin
            set_inputs(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d, vecs[v].blank);
            run_to(0);
            for (int s = 0; s < 4; s++) begin
                run_to(s * RD + 5);
                check($sformatf("vec%0d_slot%0d_an", v, s), 32'(bus.an), 32'(vecs[v].exp_an[s]));
                check($sformatf("vec%0d_slot%0d_seg", v, s), 32'(bus.seg), 32'(vecs[v].exp_seg[s]));
            end
            $display("vector %0d: A=%h B=%h C=%h D=%h blank=%b applied", v,
                     vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d, vecs[v].blank);
        end

        // Mid-frame change of D from C to E: held until the next frame load.
        set_inputs(vecs[0].a, vecs[0].b, vecs[0].c, vecs[0].d, vecs[0].blank);
        run_to(0);
        run_to(5);
        bus.D = 4'hE;
        step();
        check("tear_hold_seg", 32'(bus.seg), 32'h46);
        step();
        check("tear_hold_seg2", 32'(bus.seg), 32'h46);
        run_to(RD * 3 + 5);
        run_to(5);
        check("tear_new_seg", 32'(bus.seg), 32'h06);
        check("tear_new_an", 32'(bus.an), 32'b1110);
        $display("mid-frame change: D shows %h after next load", bus.seg);

        // Reset pulse during slot 2.
        run_to(2 * RD + 3);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("midreset_an", 32'(bus.an), 32'hF);
        check("midreset_seg", 32'(bus.seg), 32'h7F);
        run_to(FRAME - 1);
        check("midreset_dark", 32'(bus.an), 32'hF);
        step();
        check("midreset_frame_start", 32'(bus.frame_start), 32'd1);
        $display("mid-slot reset: frame_start again after %0d cycles", k);

`ifdef SEG7_DIM_EN
        // Dimming: bright=0 lights the digit for cnt=2 only.
        bus.bright = 2'd0;
        run_to(0);
        run_to(2);
        check("dim0_on", 32'(bus.an), 32'b1110);
        step();
        check("dim0_off", 32'(bus.an), 32'hF);
        bus.bright = 2'd3;
        run_to(0);
        run_to(7);
        check("dim3_on", 32'(bus.an), 32'b1110);
        $display("dimming: bright 0 and 3 windows checked");
`endif

        // Randomised traffic against the model, with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                set_inputs(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
`ifdef SEG7_DIM_EN
                bus.bright = 2'($urandom);
`endif
            end
            reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            step();
            if (bus.frame_start)
                $display("random frame at k=%0d: shadow A=%h B=%h C=%h D=%h blank=%b",
                         k, m_code[3], m_code[2], m_code[1], m_code[0], m_blank);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
